sdram_bram_responder: RTL
=========================

# sdram_bram_responder

Synthesizable responder for the SDR SDRAM command interface, backed by on-chip block RAM. It decodes the command bus driven by an SDRAM controller such as the memory tester and answers reads and writes the way an SDR chip would. This allows the controller and the pass/fail readout to be exercised in fabric, with no external SDRAM and no board-level clock phase dependence. It sits in place of the SDRAM pins in loopback builds and shares the controller clock.

## Interface
Parameters:
- ROW_BITS, 13, row address width (A bus width)
- COL_BITS, 9, column address width
- MEM_ADDR_BITS, 12, BRAM depth in 16-bit words (2^MEM_ADDR_BITS)

Ports:
- clk  in  1  controller clock; all commands sampled on rising edge
- reset  in  1  synchronous, active-high
- sdram_csn, sdram_rasn, sdram_casn, sdram_wen  in  1 each  command bus
- sdram_cke  in  1  clock enable; 0 means the command is ignored and the pipeline is held
- sdram_a  in  ROW_BITS  address
- sdram_ba  in  2  bank address
- sdram_dqm  in  2  byte mask, bit 1 = upper byte
- sdram_d_i  in  16  write data from controller
- sdram_d_o  out  16  read data
- sdram_d_oe  out  1  read data valid/drive enable
- violations  out  16  saturating protocol-violation count

## Operation
- Command decode when csn=0 and cke=1, using {rasn,casn,wen}:
  - 111 NOP
  - 011 ACTIVE
  - 101 READ
  - 100 WRITE
  - 010 PRECHARGE (A10=1 means all banks)
  - 001 AUTO REFRESH (no-op)
  - 000 LOAD MODE
  - 110 BURST TERMINATE
- csn=1 is a NOP.
- Per-bank state: open flag and open row register. ACTIVE sets both. PRECHARGE clears the open flag.
- Mode register, reset value: CL=2, BL=1, sequential.
  - LOAD MODE takes A[2:0] as BL (0→1, 1→2, 2→4, 3→8, others→1) and A[6:4] as CL (2 or 3; others→2).
- Memory address = low MEM_ADDR_BITS of {ba, open_row[ba], col}. Aliasing above BRAM size is intended.
- Burst addressing: the low log2(BL) column bits increment and wrap within the BL-aligned block; the upper bits stay fixed.
- WRITE:
  - Beat 0 is written in the command cycle from sdram_d_i.
  - Beats 1..BL-1 follow on consecutive cycles.
  - Per-byte write is suppressed where dqm is high in that beat's cycle.
- READ: beat n data appears on sdram_d_o with sdram_d_oe=1 exactly CL cycles after the cycle in which beat n was addressed. A DQM bit high 2 cycles earlier forces sdram_d_oe=0 for that beat.
- A10=1 on READ/WRITE (auto-precharge) closes the bank after the last beat.
- A new READ, WRITE, BURST TERMINATE or PRECHARGE of the bursting bank truncates the current burst.
  - Beats already addressed still emerge from the CL pipeline.
  - A new READ/WRITE starts its own burst in the same cycle.
- State machine: IDLE → RBURST or WBURST (BL>1) → IDLE after the last beat or on truncation. A READ/WRITE arriving in any state moves to the corresponding burst state.

## Timing
- Reset values:
  - sdram_d_o=0, sdram_d_oe=0, violations=0.
  - All banks closed, mode CL=2 BL=1, state IDLE.
  - The read pipeline is flushed.
- Reset asserted mid-burst aborts the burst the next cycle, with no further writes and oe=0. BRAM contents are not cleared.
- BRAM is single-port, synchronous with 1-cycle read. The CL pipeline adds CL-1 register stages after it.
- cke=0 freezes the burst counter and the CL pipeline for that cycle.
- Read and write to the same address in one cycle cannot occur. A write after a read command never alters data already in the pipeline.

## Configuration
- SDRAM_RESP_PROTOCOL_CHECK_EN defined: `violations` increments (saturating at 0xFFFF) once per cycle with any of:
  - READ/WRITE to a closed bank
  - ACTIVE to an open bank
  - LOAD MODE while any bank is open
- Macro not defined: `violations` is tied to 0 and the checking logic is absent. READ/WRITE to a closed bank then uses the last stored row for that bank.

## Structure
- The shared package `sdram_pkg` holds:
  - command encoding constants (CMD_NOP … CMD_LMR)
  - the BL/CL decode constants
  - the burst-state enum
- One sub-module, `sdram_resp_bram`: byte-write-enabled single-port 16-bit RAM, MEM_ADDR_BITS deep, so synthesis infers ECP5 DP16KD.

## Test plan
- Reset, then LOAD MODE A=0x020 (CL2, BL1); ACTIVE ba=1 row=5; WRITE col=3 d=0xA55A; READ col=3 → sdram_d_o=0xA55A with oe=1 exactly 2 cycles after READ.
- LOAD MODE A=0x033 (CL3, BL8); write burst col=6 data 0..7 → READ col=0 returns 2,3,4,5,6,7,0,1 starting 3 cycles after READ (wrap order).
- WRITE with dqm=2'b10 on beat 0, d=0x1234 over existing 0xFFFF → readback 0xFF34. Read DQM=2'b11 two cycles before beat 2 → oe=0 on beat 2 only.
- BL8 READ, then READ at another column 3 cycles later → 3 beats of the first burst, then the new burst, with no gap and no extra beats.
- With SDRAM_RESP_PROTOCOL_CHECK_EN: READ to a closed bank, then ACTIVE twice to bank 0 → violations=2. Without the macro → violations=0.
- Reset asserted during a BL8 write burst at beat 3 → beats 4..7 are not written (old data is read back), and the mode returns to CL2/BL1.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - command encodings, mode decode constants and burst-state type for the SDRAM responder
package sdram_pkg;

    // {rasn, casn, wen}
    localparam logic [2:0] CMD_LMR   = 3'b000;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_BST   = 3'b110;
    localparam logic [2:0] CMD_NOP   = 3'b111;

    localparam logic [2:0] BL_CODE_1 = 3'd0;
    localparam logic [2:0] BL_CODE_2 = 3'd1;
    localparam logic [2:0] BL_CODE_4 = 3'd2;
    localparam logic [2:0] BL_CODE_8 = 3'd3;

    localparam logic [2:0] CL_CODE_2 = 3'd2;
    localparam logic [2:0] CL_CODE_3 = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RBURST = 2'd1,
        ST_WBURST = 2'd2
    } burst_state_e;

    // Burst length kept as the mask of column bits that wrap (BL-1).
    function automatic logic [2:0] bl_mask(input logic [2:0] code);
        logic [2:0] m;
        case (code)
            BL_CODE_2: m = 3'd1;
            BL_CODE_4: m = 3'd3;
            BL_CODE_8: m = 3'd7;
            default:   m = 3'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sdram_resp_bram.sv
// rtl/sdram_resp_bram.sv - byte-write single-port 16-bit synchronous RAM backing the SDRAM responder
module sdram_resp_bram #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [1:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    logic [1:0][7:0] mem [2**ADDR_BITS];
    logic [15:0]     rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we[0]) mem[addr][0] <= wdata[7:0];
            if (we[1]) mem[addr][1] <= wdata[15:8];
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sdram_bram_responder.sv
// rtl/sdram_bram_responder.sv - BRAM-backed SDR SDRAM command responder for in-fabric loopback
// Optional protocol checking: define SDRAM_RESP_PROTOCOL_CHECK_EN.
module sdram_bram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_BITS      = 13,
    parameter int COL_BITS      = 9,
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sdram_csn,
    input  logic                sdram_rasn,
    input  logic                sdram_casn,
    input  logic                sdram_wen,
    input  logic                sdram_cke,
    input  logic [ROW_BITS-1:0] sdram_a,
    input  logic [1:0]          sdram_ba,
    input  logic [1:0]          sdram_dqm,
    input  logic [15:0]         sdram_d_i,
    output logic [15:0]         sdram_d_o,
    output logic                sdram_d_oe,
    output logic [15:0]         violations
);

    logic [2:0]          cmd;
    logic                is_rd, is_wr, is_act, is_pre, is_lmr, is_bst;
    logic [COL_BITS-1:0] cmd_col, col_mask, col_next;
    logic                pre_hits_burst, burst_cont, dqm_any;

    burst_state_e        state_q, state_d;
    logic [1:0]          bank_b_q, bank_b_d;
    logic [COL_BITS-1:0] col_b_q, col_b_d;
    logic [2:0]          left_q, left_d;
    logic                ap_q, ap_d, ap_close;

    logic [3:0]                open_q, open_d;
    logic [3:0][ROW_BITS-1:0]  row_q, row_d;
    logic [2:0]                bl_mask_q, bl_mask_d;
    logic                      cl3_q, cl3_d;

    logic                     op_rd, op_wr;
    logic [1:0]               op_bank;
    logic [COL_BITS-1:0]      op_col;
    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic [1:0]               mem_we;
    logic [15:0]              mem_rdata;

    logic        rd_v1_q, rd_v1_d, rd_v2_q, rd_v2_d, oe_q, oe_d;
    logic [15:0] rd_d2_q, rd_d2_d, dout_q, dout_d;

    always_comb begin
        cmd = CMD_NOP;
        if (!sdram_csn && sdram_cke) cmd = {sdram_rasn, sdram_casn, sdram_wen};
    end

    assign is_rd   = (cmd == CMD_READ);
    assign is_wr   = (cmd == CMD_WRITE);
    assign is_act  = (cmd == CMD_ACT);
    assign is_pre  = (cmd == CMD_PRE);
    assign is_lmr  = (cmd == CMD_LMR);
    assign is_bst  = (cmd == CMD_BST);
    assign dqm_any = |sdram_dqm;

    // Low log2(BL) column bits count and wrap; the rest of the column is frozen.
    assign cmd_col  = sdram_a[COL_BITS-1:0];
    assign col_mask = COL_BITS'(bl_mask_q);
    assign col_next = (col_b_q & ~col_mask) | ((col_b_q + COL_BITS'(1)) & col_mask);

    assign pre_hits_burst = is_pre && (sdram_a[10] || (sdram_ba == bank_b_q));
    assign burst_cont     = sdram_cke && (state_q != ST_IDLE) &&
                            !(is_rd || is_wr || is_bst || pre_hits_burst);

    always_comb begin
        op_rd    = 1'b0;
        op_wr    = 1'b0;
        op_bank  = bank_b_q;
        op_col   = col_b_q;
        state_d  = state_q;
        bank_b_d = bank_b_q;
        col_b_d  = col_b_q;
        left_d   = left_q;
        ap_d     = ap_q;
        ap_close = 1'b0;
        if (is_rd || is_wr) begin
            op_rd    = is_rd;
            op_wr    = is_wr;
            op_bank  = sdram_ba;
            op_col   = cmd_col;
            bank_b_d = sdram_ba;
            col_b_d  = cmd_col;
            left_d   = bl_mask_q;
            ap_d     = sdram_a[10];
            if (bl_mask_q == 3'd0) begin
                state_d  = ST_IDLE;
                ap_close = sdram_a[10];
            end else begin
                state_d = is_rd ? ST_RBURST : ST_WBURST;
            end
        end else if (burst_cont) begin
            op_rd   = (state_q == ST_RBURST);
            op_wr   = (state_q == ST_WBURST);
            op_col  = col_next;
            col_b_d = col_next;
            left_d  = left_q - 3'd1;
            if (left_q == 3'd1) begin
                state_d  = ST_IDLE;
                ap_close = ap_q;
            end
        end else if (is_bst || pre_hits_burst) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        bl_mask_d = bl_mask_q;
        cl3_d     = cl3_q;
        if (ap_close) open_d[op_bank] = 1'b0;
        if (is_act) begin
            open_d[sdram_ba] = 1'b1;
            row_d[sdram_ba]  = sdram_a;
        end
        if (is_pre) begin
            if (sdram_a[10]) open_d = '0;
            else             open_d[sdram_ba] = 1'b0;
        end
        if (is_lmr) begin
            bl_mask_d = bl_mask(sdram_a[2:0]);
            cl3_d     = (sdram_a[6:4] == CL_CODE_3);
        end
    end

    // The stored row is used even for a closed bank; addresses above the RAM alias.
    assign mem_addr = MEM_ADDR_BITS'({op_bank, row_q[op_bank], op_col});
    assign mem_we   = (op_wr && !reset) ? ~sdram_dqm : 2'b00;

    sdram_resp_bram #(
        .ADDR_BITS(MEM_ADDR_BITS)
    ) u_bram (
        .clk  (clk),
        .en   (sdram_cke),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(sdram_d_i),
        .rdata(mem_rdata)
    );

    // DQM masks the beat whose output cycle is two cycles later: for CL2 that is the
    // addressing cycle, for CL3 the cycle after it.
    always_comb begin
        rd_v1_d = rd_v1_q;
        rd_v2_d = rd_v2_q;
        rd_d2_d = rd_d2_q;
        oe_d    = oe_q;
        dout_d  = dout_q;
        if (sdram_cke) begin
            rd_v1_d = op_rd && (cl3_q || !dqm_any);
            rd_v2_d = rd_v1_q && !dqm_any;
            rd_d2_d = mem_rdata;
            oe_d    = cl3_q ? rd_v2_q : rd_v1_q;
            dout_d  = oe_d ? (cl3_q ? rd_d2_q : mem_rdata) : 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bank_b_q  <= '0;
            col_b_q   <= '0;
            left_q    <= '0;
            ap_q      <= 1'b0;
            open_q    <= '0;
            row_q     <= '0;
            bl_mask_q <= 3'd0;
            cl3_q     <= 1'b0;
            rd_v1_q   <= 1'b0;
            rd_v2_q   <= 1'b0;
            rd_d2_q   <= '0;
            oe_q      <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            bank_b_q  <= bank_b_d;
            col_b_q   <= col_b_d;
            left_q    <= left_d;
            ap_q      <= ap_d;
            open_q    <= open_d;
            row_q     <= row_d;
            bl_mask_q <= bl_mask_d;
            cl3_q     <= cl3_d;
            rd_v1_q   <= rd_v1_d;
            rd_v2_q   <= rd_v2_d;
            rd_d2_q   <= rd_d2_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
        end
    end

    assign sdram_d_o  = dout_q;
    assign sdram_d_oe = oe_q;

`ifdef SDRAM_RESP_PROTOCOL_CHECK_EN
    logic [15:0] viol_q, viol_d;
    logic        viol_hit;

    always_comb begin
        viol_hit = ((is_rd || is_wr) && !open_q[sdram_ba]) ||
                   (is_act && open_q[sdram_ba]) ||
                   (is_lmr && (|open_q));
        viol_d = viol_q;
        if (viol_hit && (viol_q != 16'hFFFF)) viol_d = viol_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) viol_q <= '0;
        else       viol_q <= viol_d;
    end

    assign violations = viol_q;
`else
    logic open_unused;
    assign open_unused = |open_q;
    assign violations  = 16'h0000;
`endif

endmodule
